// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - MDIO (clause 22) PHY-side management responder
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR   = 5'd1,
   parameter logic [15:0] PHY_ID1    = 16'h001C,
   parameter logic [15:0] PHY_ID2    = 16'hC915,
   parameter logic [15:0] STATUS_VAL = 16'h7869
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   output logic [15:0] ctrl_reg,
   output logic        wr_valid,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err
);

   localparam logic [15:0] CTRL_RST = 16'h1140;

   typedef enum logic [2:0] {
      IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_mdc_s1, r_mdc_s2, r_mdc_d;
   logic        r_mdio_s1, r_mdio_s2;
   logic [5:0]  r_pre_cnt;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_shift;
   logic        r_is_read;
   logic [4:0]  r_regad;
   logic [15:0] r_rdata;
   logic        r_mdio_o, r_mdio_oe;
   logic [15:0] r_ctrl;
   logic [15:0] r_scratch [0:3];
   logic        r_wr_valid, r_frame_err;
   logic [4:0]  r_wr_addr;
   logic [15:0] r_wr_data;

   logic        w_mdc_rise;
   logic        w_bit;
   logic [15:0] w_shift_in;
   logic        w_abort, w_commit, w_read_start, w_read_end;
   logic [15:0] w_read_val;

   assign w_mdc_rise = r_mdc_s2 & ~r_mdc_d;
   assign w_bit      = r_mdio_s2;
   assign w_shift_in = {r_shift[14:0], w_bit};

   assign mdio_o    = r_mdio_o;
   assign mdio_oe   = r_mdio_oe;
   assign ctrl_reg  = r_ctrl;
   assign wr_valid  = r_wr_valid;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign frame_err = r_frame_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mdc_s1  <= 1'b0;
         r_mdc_s2  <= 1'b0;
         r_mdc_d   <= 1'b0;
         r_mdio_s1 <= 1'b0;
         r_mdio_s2 <= 1'b0;
      end else begin
         r_mdc_s1  <= mdc;
         r_mdc_s2  <= r_mdc_s1;
         r_mdc_d   <= r_mdc_s2;
         r_mdio_s1 <= mdio_i;
         r_mdio_s2 <= r_mdio_s1;
      end
   end

   always_comb begin
      w_read_val = 16'h0000;
      case (r_regad)
         5'd0:    w_read_val = r_ctrl;
         5'd1:    w_read_val = STATUS_VAL;
         5'd2:    w_read_val = PHY_ID1;
         5'd3:    w_read_val = PHY_ID2;
         5'd4, 5'd5, 5'd6, 5'd7: w_read_val = r_scratch[r_regad[1:0]];
         default: w_read_val = 16'h0000;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_abort      = 1'b0;
      w_commit     = 1'b0;
      w_read_start = 1'b0;
      w_read_end   = 1'b0;
      if (w_mdc_rise) begin
         case (r_state)
            IDLE: if (!w_bit && r_pre_cnt == 6'd32) w_state_next = ST;
            ST: begin
               if (w_bit) w_state_next = OP;
               else       w_abort = 1'b1;
            end
            OP: begin
               if (r_bit_cnt == 5'd1) begin
                  if (w_shift_in[1:0] == 2'b10 || w_shift_in[1:0] == 2'b01)
                     w_state_next = PHYAD;
                  else
                     w_abort = 1'b1;
               end
            end
            PHYAD: begin
               if (r_bit_cnt == 5'd4) begin
                  if (w_shift_in[4:0] != PHY_ADDR) w_abort = 1'b1;
                  else                             w_state_next = REGAD;
               end
            end
            REGAD: if (r_bit_cnt == 5'd4) w_state_next = TA;
            TA: begin
               // Reads start driving at the first TA edge; writes just skip both TA bits
               if (r_is_read) begin
                  w_read_start = 1'b1;
                  w_state_next = RDATA;
               end else if (r_bit_cnt == 5'd1) begin
                  w_state_next = WDATA;
               end
            end
            RDATA: begin
               if (r_bit_cnt == 5'd16) begin
                  w_read_end   = 1'b1;
                  w_state_next = IDLE;
               end
            end
            WDATA: begin
               if (r_bit_cnt == 5'd15) begin
                  w_commit     = 1'b1;
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
         if (w_abort) w_state_next = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre_cnt <= 6'd0;
         r_bit_cnt <= 5'd0;
         r_shift   <= 16'h0000;
         r_is_read <= 1'b0;
         r_regad   <= 5'd0;
      end else if (w_mdc_rise) begin
         r_shift <= w_shift_in;
         if (w_state_next != r_state || r_state == IDLE) r_bit_cnt <= 5'd0;
         else                                            r_bit_cnt <= r_bit_cnt + 5'd1;
         // Preamble count only survives while we stay in IDLE; any frame activity restarts it
         if (r_state == IDLE && w_state_next == IDLE) begin
            if (!w_bit)                    r_pre_cnt <= 6'd0;
            else if (r_pre_cnt != 6'd32)   r_pre_cnt <= r_pre_cnt + 6'd1;
         end else begin
            r_pre_cnt <= 6'd0;
         end
         if (r_state == OP && r_bit_cnt == 5'd1) r_is_read <= w_shift_in[1];
         if (r_state == REGAD && r_bit_cnt == 5'd4) r_regad <= w_shift_in[4:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mdio_o  <= 1'b1;
         r_mdio_oe <= 1'b0;
         r_rdata   <= 16'h0000;
      end else if (w_read_start) begin
         r_mdio_oe <= 1'b1;
         r_mdio_o  <= 1'b0;
         r_rdata   <= w_read_val;
      end else if (w_read_end || w_abort) begin
         r_mdio_oe <= 1'b0;
         r_mdio_o  <= 1'b1;
      end else if (w_mdc_rise && r_state == RDATA) begin
         r_mdio_o <= r_rdata[15];
         r_rdata  <= {r_rdata[14:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl      <= CTRL_RST;
         for (int i = 0; i < 4; i++) r_scratch[i] <= 16'h0000;
         r_wr_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_wr_addr   <= 5'd0;
         r_wr_data   <= 16'h0000;
      end else begin
         r_wr_valid  <= w_commit;
         r_frame_err <= w_abort;
         if (w_commit) begin
            r_wr_addr <= r_regad;
            r_wr_data <= w_shift_in;
            if (r_regad == 5'd0) begin
               // Soft reset is self-clearing: bit 15 is never stored
               if (w_shift_in[15]) begin
                  r_ctrl <= CTRL_RST;
                  for (int i = 0; i < 4; i++) r_scratch[i] <= 16'h0000;
               end else begin
                  r_ctrl <= w_shift_in;
               end
            end else if (r_regad[4:2] == 3'b001) begin
               r_scratch[r_regad[1:0]] <= w_shift_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb/tb_mdio_phy_responder.sv - directed self-checking bench for mdio_phy_responder
module tb_mdio_phy_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mdc = 1'b0;
   logic        mdio_i = 1'b1;
   logic        mdio_o, mdio_oe;
   logic [15:0] ctrl_reg;
   logic        wr_valid;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_err;

   int total = 0;
   int bad = 0;
   int wv_cnt = 0;
   int fe_cnt = 0;
   int oe_cnt = 0;

   mdio_phy_responder dut (
      .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i),
      .mdio_o(mdio_o), .mdio_oe(mdio_oe), .ctrl_reg(ctrl_reg),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid)  wv_cnt++;
      if (frame_err) fe_cnt++;
      if (mdio_oe)   oe_cnt++;
   end

   task automatic bit_slot(input logic b);
      mdio_i = b;
      mdc = 1'b0;
      #80;
      mdc = 1'b1;
      #80;
   endtask

   task automatic send_header(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
      logic [13:0] hdr;
      hdr = {2'b01, op, phy, ra};
      for (int i = 0; i < 32; i++) bit_slot(1'b1);
      for (int i = 13; i >= 0; i--) bit_slot(hdr[i]);
   endtask

   task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                             output logic [15:0] data, output int terr);
      logic exp_oe;
      send_header(2'b10, phy, ra);
      terr = 0;
      data = 16'h0000;
      for (int j = 0; j < 19; j++) begin
         mdio_i = 1'b1;
         mdc = 1'b0;
         #80;
         exp_oe = (j >= 1 && j <= 17);
         if (mdio_oe !== exp_oe) terr++;
         if (j == 1 && mdio_o !== 1'b0) terr++;
         if (j >= 2 && j <= 17) data = {data[14:0], mdio_o};
         mdc = 1'b1;
         #80;
      end
   endtask

   task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
      send_header(2'b01, phy, ra);
      bit_slot(1'b1);
      bit_slot(1'b0);
      for (int i = 15; i >= 0; i--) bit_slot(d[i]);
      bit_slot(1'b1);
   endtask

   task automatic test_reset;
      #33;
      total += 7;
      if (mdio_oe !== 1'b0)       begin bad++; $display("FAIL reset_oe got=%b want=0", mdio_oe); end
      if (mdio_o !== 1'b1)        begin bad++; $display("FAIL reset_o got=%b want=1", mdio_o); end
      if (ctrl_reg !== 16'h1140)  begin bad++; $display("FAIL reset_ctrl got=%h want=1140", ctrl_reg); end
      if (wr_valid !== 1'b0)      begin bad++; $display("FAIL reset_wr_valid got=%b want=0", wr_valid); end
      if (frame_err !== 1'b0)     begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
      if (wr_addr !== 5'd0)       begin bad++; $display("FAIL reset_wr_addr got=%h want=0", wr_addr); end
      if (wr_data !== 16'h0000)   begin bad++; $display("FAIL reset_wr_data got=%h want=0000", wr_data); end
      rst = 1'b0;
      #40;
   endtask

   task automatic test_read_map;
      logic [15:0] d;
      int          terr;
      logic [4:0]  addrs [5] = '{5'd2, 5'd3, 5'd1, 5'd0, 5'd9};
      logic [15:0] exps  [5] = '{16'h001C, 16'hC915, 16'h7869, 16'h1140, 16'h0000};
      int          fe0;
      fe0 = fe_cnt;
      for (int k = 0; k < 5; k++) begin
         read_frame(5'd1, addrs[k], d, terr);
         total += 2;
         if (d !== exps[k]) begin bad++; $display("FAIL read_data reg=%0d got=%h want=%h", addrs[k], d, exps[k]); end
         if (terr !== 0)    begin bad++; $display("FAIL read_timing reg=%0d errors=%0d want=0", addrs[k], terr); end
      end
      total++;
      if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL read_no_err got=%0d want=0", fe_cnt - fe0); end
   endtask

   task automatic test_write_scratch;
      logic [15:0] d;
      int          terr, wv0, oe0;
      wv0 = wv_cnt;
      oe0 = oe_cnt;
      write_frame(5'd1, 5'd4, 16'hA5C3);
      total += 4;
      if (wv_cnt - wv0 !== 1)     begin bad++; $display("FAIL wr_pulse got=%0d want=1", wv_cnt - wv0); end
      if (wr_addr !== 5'd4)       begin bad++; $display("FAIL wr_addr got=%0d want=4", wr_addr); end
      if (wr_data !== 16'hA5C3)   begin bad++; $display("FAIL wr_data got=%h want=a5c3", wr_data); end
      if (oe_cnt - oe0 !== 0)     begin bad++; $display("FAIL wr_oe got=%0d want=0", oe_cnt - oe0); end
      read_frame(5'd1, 5'd4, d, terr);
      total += 2;
      if (d !== 16'hA5C3) begin bad++; $display("FAIL scratch_readback got=%h want=a5c3", d); end
      if (terr !== 0)     begin bad++; $display("FAIL scratch_timing errors=%0d want=0", terr); end
   endtask

   task automatic test_short_preamble;
      logic [13:0] hdr;
      int          fe0, oe0;
      fe0 = fe_cnt;
      oe0 = oe_cnt;
      hdr = {2'b01, 2'b10, 5'd1, 5'd2};
      bit_slot(1'b0);
      for (int i = 0; i < 31; i++) bit_slot(1'b1);
      bit_slot(1'b0);
      for (int i = 13; i >= 0; i--) bit_slot(hdr[i]);
      for (int i = 0; i < 19; i++) bit_slot(1'b1);
      total += 2;
      if (oe_cnt - oe0 !== 0) begin bad++; $display("FAIL short_pre_oe got=%0d want=0", oe_cnt - oe0); end
      if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL short_pre_err got=%0d want=0", fe_cnt - fe0); end
   endtask

   task automatic test_wrong_phy;
      logic [15:0] d;
      int          terr, fe0, oe0;
      logic [4:0]  phy;
      phy = 5'd2;
      fe0 = fe_cnt;
      oe0 = oe_cnt;
      for (int i = 0; i < 32; i++) bit_slot(1'b1);
      bit_slot(1'b0); bit_slot(1'b1); bit_slot(1'b1); bit_slot(1'b0);
      for (int i = 4; i >= 1; i--) bit_slot(phy[i]);
      total++;
      if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL phy_err_early got=%0d want=0", fe_cnt - fe0); end
      bit_slot(phy[0]);
      total++;
      if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL phy_err_pulse got=%0d want=1", fe_cnt - fe0); end
      for (int i = 0; i < 24; i++) bit_slot(1'b1);
      total++;
      if (oe_cnt - oe0 !== 0) begin bad++; $display("FAIL phy_oe got=%0d want=0", oe_cnt - oe0); end
      read_frame(5'd1, 5'd2, d, terr);
      total += 2;
      if (d !== 16'h001C) begin bad++; $display("FAIL phy_recover got=%h want=001c", d); end
      if (terr !== 0)     begin bad++; $display("FAIL phy_recover_timing errors=%0d want=0", terr); end
   endtask

   task automatic test_soft_reset;
      logic [15:0] d;
      int          terr, wv0;
      write_frame(5'd1, 5'd0, 16'h2100);
      total++;
      if (ctrl_reg !== 16'h2100) begin bad++; $display("FAIL ctrl_write got=%h want=2100", ctrl_reg); end
      wv0 = wv_cnt;
      write_frame(5'd1, 5'd2, 16'hFFFF);
      total += 2;
      if (wv_cnt - wv0 !== 1) begin bad++; $display("FAIL ro_wr_pulse got=%0d want=1", wv_cnt - wv0); end
      if (wr_addr !== 5'd2)   begin bad++; $display("FAIL ro_wr_addr got=%0d want=2", wr_addr); end
      read_frame(5'd1, 5'd2, d, terr);
      total++;
      if (d !== 16'h001C) begin bad++; $display("FAIL ro_unchanged got=%h want=001c", d); end
      write_frame(5'd1, 5'd5, 16'h1234);
      write_frame(5'd1, 5'd0, 16'h8000);
      total++;
      if (ctrl_reg !== 16'h1140) begin bad++; $display("FAIL soft_rst_ctrl got=%h want=1140", ctrl_reg); end
      read_frame(5'd1, 5'd4, d, terr);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL soft_rst_reg4 got=%h want=0000", d); end
      read_frame(5'd1, 5'd5, d, terr);
      total++;
      if (d !== 16'h0000) begin bad++; $display("FAIL soft_rst_reg5 got=%h want=0000", d); end
   endtask

   task automatic test_reset_mid_read;
      logic [15:0] d;
      int          terr;
      write_frame(5'd1, 5'd0, 16'h0100);
      total++;
      if (ctrl_reg !== 16'h0100) begin bad++; $display("FAIL pre_ctrl got=%h want=0100", ctrl_reg); end
      send_header(2'b10, 5'd1, 5'd2);
      for (int j = 0; j < 9; j++) bit_slot(1'b1);
      mdio_i = 1'b1;
      mdc = 1'b0;
      #80;
      total += 2;
      if (mdio_oe !== 1'b1) begin bad++; $display("FAIL d8_oe got=%b want=1", mdio_oe); end
      if (mdio_o !== 1'b0)  begin bad++; $display("FAIL d8_bit got=%b want=0", mdio_o); end
      rst = 1'b1;
      #1;
      total += 2;
      if (mdio_oe !== 1'b0)      begin bad++; $display("FAIL midrst_oe got=%b want=0", mdio_oe); end
      if (ctrl_reg !== 16'h1140) begin bad++; $display("FAIL midrst_ctrl got=%h want=1140", ctrl_reg); end
      #40;
      rst = 1'b0;
      #80;
      read_frame(5'd1, 5'd3, d, terr);
      total += 2;
      if (d !== 16'hC915) begin bad++; $display("FAIL post_rst_read got=%h want=c915", d); end
      if (terr !== 0)     begin bad++; $display("FAIL post_rst_timing errors=%0d want=0", terr); end
   endtask

   initial begin
      test_reset;
      test_read_map;
      test_write_scratch;
      test_short_preamble;
      test_wrong_phy;
      test_soft_reset;
      test_reset_mid_read;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
